// File: rtl/req_chan_arb_pkg.sv
// Shared definitions for the request-channel arbiter: master count, field
// widths, FSM state codes and the per-master request beat layout.
package req_chan_arb_pkg;

    localparam int unsigned NUM_MST = 4;
    localparam int unsigned MST_IW  = 2;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ATOP_W  = 6;
    localparam int unsigned TMO_W   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GRNT = 2'b01,
        ARB_BUSY = 2'b10,
        ARB_DEFO = 2'b11
    } arb_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [ATOP_W-1:0] atop;
    } req_beat_t;

    // Master index to one-hot vector.
    function automatic logic [NUM_MST-1:0] idx2onehot(input logic [MST_IW-1:0] idx);
        logic [NUM_MST-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/req_chan_arb_rr_pick.sv
// Round-robin winner search, purely combinational.
// Ports:
//   req  - per-master request vector
//   last - index of the previous winner; search starts at last+1
//   win  - winning master index (0 when no request)
//   any  - at least one request present
module rr_pick
    import req_chan_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] req,
    input  logic [MST_IW-1:0]  last,
    output logic [MST_IW-1:0]  win,
    output logic               any
);

    logic [MST_IW-1:0] idx;
    logic              found;

    // Visit last+1 .. last+4 (mod 4); the 2-bit add provides the wrap.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        any   = |req;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            idx = last + MST_IW'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_chan_arb.sv
// Four-master round-robin arbiter for a request (A) channel.
// One transfer per arbitration: IDLE samples requests, GRNT pulses the grant,
// BUSY forwards the selected master's request until a slave handshake.
// Optional build macro REQ_ARB_TMO_EN adds a grant-to-valid timeout that
// returns to IDLE after ARB_TMO BUSY cycles without valid and sets a sticky
// tmo_err; without it tmo_err is tied low.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   req_rq / gnt_rq      - per-master bus request / one-cycle one-hot grant
//   m_a_valid/m_a_ready  - per-master request handshake
//   m_a_id/addr/atop     - per-master request fields, packed by master index
//   s_a_*                - slave-side request channel
//   tmo_err              - sticky timeout flag
module req_chan_arb
    import req_chan_arb_pkg::*;
#(
    parameter logic [7:0] ARB_TMO = 8'd32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MST-1:0]          req_rq,
    output logic [NUM_MST-1:0]          gnt_rq,
    input  logic [NUM_MST-1:0]          m_a_valid,
    output logic [NUM_MST-1:0]          m_a_ready,
    input  logic [NUM_MST*ID_W-1:0]     m_a_id,
    input  logic [NUM_MST*ADDR_W-1:0]   m_a_addr,
    input  logic [NUM_MST*ATOP_W-1:0]   m_a_atop,
    output logic                        s_a_valid,
    input  logic                        s_a_ready,
    output logic [ID_W-1:0]             s_a_id,
    output logic [ADDR_W-1:0]           s_a_addr,
    output logic [ATOP_W-1:0]           s_a_atop,
    output logic                        tmo_err
);

    arb_state_e         state_q, state_d;
    logic [MST_IW-1:0]  last_q, last_d;
    logic [MST_IW-1:0]  sel_q, sel_d;
    logic [NUM_MST-1:0] gnt_q, gnt_d;
    logic [MST_IW-1:0]  win;
    logic               any_req;
    logic               tmo_hit;
    req_beat_t          beat [NUM_MST];

    rr_pick u_rr_pick (
        .req  (req_rq),
        .last (last_q),
        .win  (win),
        .any  (any_req)
    );

    // Regroup the flat per-master buses into one beat per master.
    for (genvar i = 0; i < NUM_MST; i++) begin : g_beat
        assign beat[i] = '{id:   m_a_id[ID_W*i +: ID_W],
                           addr: m_a_addr[ADDR_W*i +: ADDR_W],
                           atop: m_a_atop[ATOP_W*i +: ATOP_W]};
    end

    // Slave-side request follows the selected master.
    assign s_a_valid = (state_q == ARB_BUSY) & m_a_valid[sel_q];
    assign s_a_id    = beat[sel_q].id;
    assign s_a_addr  = beat[sel_q].addr;
    assign s_a_atop  = beat[sel_q].atop;
    assign gnt_rq    = gnt_q;

    // Ready is returned only to the selected master.
    always_comb begin
        m_a_ready = '0;
        if ((state_q == ARB_BUSY) && s_a_ready) begin
            m_a_ready = idx2onehot(sel_q);
        end
    end

`ifdef REQ_ARB_TMO_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    // Counter is cleared while granting so it starts at zero in BUSY; the
    // ARB_TMO-th valid-less BUSY cycle is the one that times out.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = (state_q == ARB_BUSY) && !s_a_valid &&
                    (tmo_cnt_q == TMO_W'(ARB_TMO - 8'd1));
        if (state_q == ARB_GRNT) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ARB_BUSY) && !s_a_valid) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        tmo_err_d = tmo_err_q | tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign tmo_err = tmo_err_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign tmo_err    = 1'b0;
    assign unused_tmo = ^ARB_TMO;
`endif

    // Next-state, winner capture and grant pulse.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_GRNT;
                    last_d  = win;
                    sel_d   = win;
                    gnt_d   = idx2onehot(win);
                end
            end
            ARB_GRNT: begin
                state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                if ((s_a_valid && s_a_ready) || tmo_hit) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DEFO: begin
                state_d = ARB_DEFO;
            end
        endcase
    end

    // last resets to 3 so master 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= MST_IW'(3);
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_req_chan_arb.sv
// Scoreboard bench for req_chan_arb: the driver predicts each grant and
// transfer with a round-robin model and queues them; a negedge monitor
// pops and compares whenever the DUT shows a grant or a handshake.
module tb_req_chan_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_rq;
    logic [3:0]   gnt_rq;
    logic [3:0]   m_a_valid;
    logic [3:0]   m_a_ready;
    logic [15:0]  m_a_id;
    logic [127:0] m_a_addr;
    logic [23:0]  m_a_atop;
    logic         s_a_valid;
    logic         s_a_ready;
    logic [3:0]   s_a_id;
    logic [31:0]  s_a_addr;
    logic [5:0]   s_a_atop;
    logic         tmo_err;

    always #5 clk = ~clk;

    req_chan_arb #(.ARB_TMO(8'd32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_rq    (req_rq),
        .gnt_rq    (gnt_rq),
        .m_a_valid (m_a_valid),
        .m_a_ready (m_a_ready),
        .m_a_id    (m_a_id),
        .m_a_addr  (m_a_addr),
        .m_a_atop  (m_a_atop),
        .s_a_valid (s_a_valid),
        .s_a_ready (s_a_ready),
        .s_a_id    (s_a_id),
        .s_a_addr  (s_a_addr),
        .s_a_atop  (s_a_atop),
        .tmo_err   (tmo_err)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [5:0]  atop;
        logic [3:0]  rdy;
    } xfer_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_gnt_q [$];
    xfer_t exp_xfer_q [$];
    int    mdl_last;

    logic [3:0] obs_gnt, obs_mar;
    logic       obs_hs, obs_tmo, obs_sav;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Round-robin reference: first requester after the previous winner.
    function automatic int rr_model(input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (mdl_last + k) % 4;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Observe one cycle at negedge, then move to just after the next posedge.
    task automatic step();
        @(negedge clk);
        obs_gnt = gnt_rq;
        obs_hs  = s_a_valid & s_a_ready;
        obs_tmo = tmo_err;
        obs_sav = s_a_valid;
        obs_mar = m_a_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        m_a_id   = 16'($urandom);
        m_a_addr = {$urandom, $urandom, $urandom, $urandom};
        m_a_atop = 24'($urandom);
    endtask

    task automatic issue(input logic [3:0] mask, input bit push_xfer, output int w);
        xfer_t x;
        w        = rr_model(mask);
        mdl_last = w;
        req_rq   = mask;
        exp_gnt_q.push_back(w);
        if (push_xfer) begin
            x.id   = m_a_id[4*w +: 4];
            x.addr = m_a_addr[32*w +: 32];
            x.atop = m_a_atop[6*w +: 6];
            x.rdy  = '0;
            x.rdy[w] = 1'b1;
            exp_xfer_q.push_back(x);
        end
    endtask

    // mode: 0 hold request, 1 withdraw during grant, 2 random request noise
    task automatic wait_grant(input int mode);
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (mode == 1) req_rq = '0;
        end while (obs_gnt == 4'd0 && n < 64);
        check("grant_seen", 32'(obs_gnt != 4'd0), 32'd1);
    endtask

    task automatic complete(input int w, input int mode, input int vdly, input bit stall);
        int n;
        bit ok;
        m_a_valid    = 4'($urandom);
        m_a_valid[w] = 1'b0;
        if (mode == 2) req_rq = 4'($urandom);
        if (vdly > 0) begin
            ok = 1'b1;
            for (int i = 0; i < vdly; i++) begin
                step();
                if (obs_sav) ok = 1'b0;
            end
            check("valid_from_unselected", 32'(ok), 32'd1);
        end
        m_a_valid[w] = 1'b1;
        if (stall) begin
            s_a_ready = 1'b0;
            ok = 1'b1;
            repeat (10) begin
                step();
                if (!obs_sav || obs_mar != 4'd0) ok = 1'b0;
            end
            check("stall_valid_held", 32'(ok), 32'd1);
            s_a_ready = 1'b1;
            step();
            check("stall_release_hs", 32'(obs_hs), 32'd1);
        end else begin
            n = 0;
            do begin
                s_a_ready = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end while (!obs_hs && n < 200);
            check("hs_seen", 32'(obs_hs), 32'd1);
        end
        m_a_valid = '0;
        req_rq    = '0;
        s_a_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_rq    = '0;
        m_a_valid = '0;
        s_a_ready = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        mdl_last = 3;
    endtask

    // Monitor: grant and handshake scoreboard plus stall stability.
    int         mon_e;
    logic [3:0] mon_oh;
    xfer_t      mon_x;
    logic [31:0] prev_addr;
    logic [3:0]  prev_id;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (gnt_rq != 4'd0) begin
            if (exp_gnt_q.size() == 0) begin
                check("unexpected_grant", 32'(gnt_rq), 32'd0);
            end else begin
                mon_e  = exp_gnt_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e] = 1'b1;
                check("grant_onehot", 32'(gnt_rq), 32'(mon_oh));
            end
        end
        if (s_a_valid && s_a_ready) begin
            if (exp_xfer_q.size() == 0) begin
                check("unexpected_handshake", 32'(s_a_addr), 32'd0);
            end else begin
                mon_x = exp_xfer_q.pop_front();
                check("hs_id", 32'(s_a_id), 32'(mon_x.id));
                check("hs_addr", s_a_addr, mon_x.addr);
                check("hs_atop", 32'(s_a_atop), 32'(mon_x.atop));
                check("hs_m_ready", 32'(m_a_ready), 32'(mon_x.rdy));
            end
        end
        if (s_a_valid && !s_a_ready) begin
            check("stall_m_ready", 32'(m_a_ready), 32'd0);
            if (prev_stall) begin
                check("stall_addr_stable", s_a_addr, prev_addr);
                check("stall_id_stable", 32'(s_a_id), 32'(prev_id));
            end
            prev_stall = 1'b1;
            prev_addr  = s_a_addr;
            prev_id    = s_a_id;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  w, w2, n;
        bit  t32, t33, ok;
        logic [3:0] m;

        rst_n     = 1'b0;
        req_rq    = '0;
        m_a_valid = '0;
        s_a_ready = 1'b0;
        m_a_id    = '0;
        m_a_addr  = '0;
        m_a_atop  = '0;
        mdl_last  = 3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_gnt", 32'(gnt_rq), 32'd0);
        check("rst_s_valid", 32'(s_a_valid), 32'd0);
        check("rst_m_ready", 32'(m_a_ready), 32'd0);
        check("rst_tmo_err", 32'(tmo_err), 32'd0);
        @(posedge clk);
        #1;

        // Single request from master 2 with fixed payload.
        rand_payload();
        m_a_addr[95:64] = 32'h1000_0040;
        m_a_id[11:8]    = 4'b1001;
        issue(4'b0100, 1'b1, w);
        wait_grant(0);
        complete(w, 0, 0, 1'b0);

        // All masters requesting continuously from reset: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            issue(4'b1111, 1'b1, w);
            wait_grant(0);
            complete(w, 0, $urandom_range(0, 2), 1'b0);
        end

        // Slave stall for 10 cycles with valid held.
        rand_payload();
        issue(4'($urandom_range(1, 15)), 1'b1, w);
        wait_grant(2);
        complete(w, 2, 1, 1'b1);

        // Request withdrawn during grant still gets a transfer.
        rand_payload();
        issue(4'($urandom_range(1, 15)), 1'b1, w);
        wait_grant(1);
        complete(w, 1, 3, 1'b0);

`ifdef REQ_ARB_TMO_EN
        // Granted master never asserts valid: timeout after 32 BUSY cycles.
        rand_payload();
        issue(4'b0010, 1'b0, w);
        wait_grant(0);
        m_a_valid = '0;
        s_a_ready = 1'b1;
        issue(4'b1000, 1'b1, w2);
        n   = 0;
        t32 = 1'b1;
        t33 = 1'b0;
        do begin
            step();
            n++;
            if (n == 32) t32 = obs_tmo;
            if (n == 33) t33 = obs_tmo;
        end while (obs_gnt == 4'd0 && n < 64);
        check("tmo_regrant_latency", 32'(n), 32'd34);
        check("tmo_err_before", 32'(t32), 32'd0);
        check("tmo_err_after", 32'(t33), 32'd1);
        complete(w2, 0, 0, 1'b0);
        check("tmo_err_sticky", 32'(tmo_err), 32'd1);
`else
        // Without the timeout BUSY is left only by a handshake.
        rand_payload();
        issue(4'b0010, 1'b1, w);
        wait_grant(0);
        m_a_valid = '0;
        s_a_ready = 1'b1;
        req_rq    = 4'b1000;
        ok = 1'b1;
        repeat (40) begin
            step();
            if (obs_gnt != 4'd0 || obs_tmo || obs_hs || obs_mar != 4'b0010) ok = 1'b0;
        end
        check("no_tmo_stays_busy", 32'(ok), 32'd1);
        complete(w, 0, 0, 1'b0);
`endif

        // Reset for one cycle in the middle of BUSY.
        rand_payload();
        issue(4'($urandom_range(1, 15)), 1'b0, w);
        wait_grant(0);
        m_a_valid[w] = 1'b1;
        s_a_ready    = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        s_a_ready = 1'b1;
        mdl_last  = 3;
        rand_payload();
        issue(4'b1111, 1'b1, w2);
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt_rq), 32'd0);
        check("post_rst_s_valid", 32'(s_a_valid), 32'd0);
        check("post_rst_m_ready", 32'(m_a_ready), 32'd0);
        check("post_rst_tmo_err", 32'(tmo_err), 32'd0);
        @(posedge clk);
        #1;
        wait_grant(0);
        complete(w2, 0, 1, 1'b0);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            int mode;
            rand_payload();
            m    = 4'($urandom_range(1, 15));
            mode = $urandom_range(0, 2);
            issue(m, 1'b1, w);
            wait_grant(mode);
            complete(w, mode, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        repeat (5) step();
        check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("xfer_queue_drained", 32'(exp_xfer_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
